mem_port_arbiter: RTL and testbench

- Shares the single memory_interface command/data channel between two requesters: port 0 is instruction fetch, port 1 is decoder data access.
- Latches one requester's command and drives it onto the tx command channel.
- Routes that requester's tx payload out, and routes rx strobes back to it only.
- Holds ownership until the transaction completes. One outstanding transaction at a time; round-robin between ports.

---
 rtl/mem_port_arbiter_pkg.sv | 29 ++
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter_rr_arbiter2.sv | 24 ++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// mem_port_arbiter_pkg
// Shared constants and state encoding for the two-port memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  // Memory interface command width and the header codes used by requesters
  localparam int TX_CMD_BITS = 8;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16  = 8'h03;
  localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 8'h02;

  // Serial payload width per cycle and nominal 16-bit payload length
  localparam int NSHIFT         = 2;
  localparam int PAYLOAD_CYCLES = 8;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_XFER    = 2'd2,
    ST_RX_WAIT = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if
// Requester-side and memory-side signal bundle of the memory port arbiter.
// master: the arbiter's view.  slave: the surrounding system's view.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int NREQ     = 2,
  parameter int CMD_BITS = 8,
  parameter int IO_BITS  = 2
);
  // requester side
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*CMD_BITS-1:0] req_cmd;
  logic [NREQ-1:0]          req_expect_rx;
  logic [NREQ*IO_BITS-1:0]  req_tx_data;
  logic [NREQ-1:0]          req_started;
  logic [NREQ-1:0]          req_tx_data_next;
  logic [NREQ-1:0]          req_rx_data_valid;
  logic [NREQ-1:0]          req_done;
  // memory interface side
  logic                     tx_command_valid;
  logic [CMD_BITS-1:0]      tx_command;
  logic                     tx_command_started;
  logic [IO_BITS-1:0]       tx_data;
  logic                     tx_data_next;
  logic                     tx_done;
  logic                     rx_data_valid;
  logic                     rx_done;
  // status
  logic                     busy;
  logic                     owner;
  logic                     protocol_error;

  modport master (
    input  req_valid, req_cmd, req_expect_rx, req_tx_data,
    output req_started, req_tx_data_next, req_rx_data_valid, req_done,
    output tx_command_valid, tx_command, tx_data,
    input  tx_command_started, tx_data_next, tx_done, rx_data_valid, rx_done,
    output busy, owner, protocol_error
  );

  modport slave (
    output req_valid, req_cmd, req_expect_rx, req_tx_data,
    input  req_started, req_tx_data_next, req_rx_data_valid, req_done,
    input  tx_command_valid, tx_command, tx_data,
    output tx_command_started, tx_data_next, tx_done, rx_data_valid, rx_done,
    input  busy, owner, protocol_error
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// ============================================================================
// rr_arbiter2
// Combinational two-way round-robin grant selection. The round-robin pointer
// is held by the parent so this block stays stateless.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr_next,
  output logic       grant_valid,
  output logic       grant_idx
);

  // A lone requester wins outright; a tie is broken by the pointer
  always_comb begin
    grant_valid = |req;
    grant_idx   = (req == 2'b11) ? rr_next : req[1];
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
// Shares one memory interface command/data channel between instruction fetch
// (port 0) and decoder data access (port 1). One transaction at a time, the
// owner keeps the channel until tx_done (writes) or rx_done (reads).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int IO_BITS  = NSHIFT,
  parameter int CMD_BITS = TX_CMD_BITS,
  parameter int NREQ     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master bus
);

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic                rr_next_q, rr_next_d;
  logic [CMD_BITS-1:0] cmd_q, cmd_d;
  logic                expect_rx_q, expect_rx_d;
  logic                perr_q, perr_d;

  logic                grant_valid;
  logic                grant_idx;
  logic                done_w;

  rr_arbiter2 u_rr (
    .req         (bus.req_valid[1:0]),
    .rr_next     (rr_next_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Next-state, latch of the granted command and stray-event detection
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_next_d   = rr_next_q;
    cmd_d       = cmd_q;
    expect_rx_d = expect_rx_q;
    perr_d      = perr_q;
    done_w      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.tx_command_started || bus.tx_done || bus.rx_done) perr_d = 1'b1;
        if (grant_valid) begin
          owner_d     = grant_idx;
          cmd_d       = bus.req_cmd[grant_idx*CMD_BITS +: CMD_BITS];
          expect_rx_d = bus.req_expect_rx[grant_idx];
          rr_next_d   = ~grant_idx;
          state_d     = ST_CMD;
        end
      end
      ST_CMD: begin
        if (bus.rx_done) perr_d = 1'b1;
        if (bus.tx_command_started) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (bus.rx_done && !expect_rx_q) perr_d = 1'b1;
        if (bus.tx_done) begin
          // a read whose rx_done lands with tx_done completes immediately
          if (!expect_rx_q || bus.rx_done) begin
            done_w  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RX_WAIT;
          end
        end
      end
      ST_RX_WAIT: begin
        if (bus.rx_done) begin
          done_w  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rr_next_q   <= 1'b0;
      cmd_q       <= '0;
      expect_rx_q <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_next_q   <= rr_next_d;
      cmd_q       <= cmd_d;
      expect_rx_q <= expect_rx_d;
      perr_q      <= perr_d;
    end
  end

  // Route memory strobes to the owning port only; everyone else sees 0
  always_comb begin
    bus.req_started       = '0;
    bus.req_tx_data_next  = '0;
    bus.req_rx_data_valid = '0;
    bus.req_done          = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == i[0]) begin
        bus.req_started[i]       = (state_q == ST_CMD) && bus.tx_command_started;
        bus.req_tx_data_next[i]  = (state_q == ST_XFER) && bus.tx_data_next;
        bus.req_rx_data_valid[i] = ((state_q == ST_XFER) || (state_q == ST_RX_WAIT))
                                   && bus.rx_data_valid;
        bus.req_done[i]          = done_w;
      end
    end
  end

  // Memory-side outputs and status, all derived from registered state
  always_comb begin
    bus.tx_command_valid = (state_q == ST_CMD);
    bus.tx_command       = cmd_q;
    bus.tx_data          = (state_q == ST_XFER) ? bus.req_tx_data[owner_q*IO_BITS +: IO_BITS]
                                                : '0;
    bus.busy             = (state_q != ST_IDLE);
    bus.owner            = owner_q;
    bus.protocol_error   = perr_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized traffic phase checked against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int IOB = NSHIFT;
  localparam int CB  = TX_CMD_BITS;
  localparam int NR  = 2;
  localparam int TDW = NR * IOB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NREQ(NR), .CMD_BITS(CB), .IO_BITS(IOB)) bus ();

  mem_port_arbiter #(.IO_BITS(IOB), .CMD_BITS(CB), .NREQ(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // model: which port won most recently; a tie goes to the other one
  int          last_grant;
  logic [CB-1:0] cmd [2];
  logic        expr [2];
  logic        perr_exp;
  int          rx_seen0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] m);
    if (m == 2'b01) return 0;
    if (m == 2'b10) return 1;
    return (last_grant == 0) ? 1 : 0;
  endfunction

  function automatic logic [1:0] onehot(input int p);
    return (p == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem_side();
    bus.tx_command_started = 1'b0;
    bus.tx_data_next       = 1'b0;
    bus.tx_done            = 1'b0;
    bus.rx_data_valid      = 1'b0;
    bus.rx_done            = 1'b0;
  endtask

  // IDLE cycle with a new request pattern, grant, CMD phase, command accept
  task automatic start_txn(input logic [1:0] mask, input logic e0, input logic e1,
                           input int cmd_wait, output int w);
    cmd[0]  = CB'($urandom);
    cmd[1]  = CB'($urandom);
    expr[0] = e0;
    expr[1] = e1;
    bus.req_valid     = mask;
    bus.req_cmd       = {cmd[1], cmd[0]};
    bus.req_expect_rx = {e1, e0};
    #3;
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_cmd_valid", 32'(bus.tx_command_valid), 0);
    chk("idle_strobes", 32'({bus.req_started, bus.req_tx_data_next,
                             bus.req_rx_data_valid, bus.req_done}), 0);
    chk("idle_tx_data", 32'(bus.tx_data), 0);
    w = pick(mask);
    last_grant = w;
    next_cycle();
    // post-grant changes must not leak into the latched transaction
    bus.req_cmd       = (2*CB)'($urandom);
    bus.req_expect_rx = 2'($urandom);
    for (int k = 0; k < cmd_wait; k++) begin
      #3;
      chk("cmd_busy", 32'(bus.busy), 1);
      chk("cmd_owner", 32'(bus.owner), 32'(w));
      chk("cmd_valid", 32'(bus.tx_command_valid), 1);
      chk("cmd_value", 32'(bus.tx_command), 32'(cmd[w]));
      chk("cmd_no_started", 32'(bus.req_started), 0);
      next_cycle();
    end
    bus.tx_command_started = 1'b1;
    #3;
    chk("start_valid", 32'(bus.tx_command_valid), 1);
    chk("start_cmd", 32'(bus.tx_command), 32'(cmd[w]));
    chk("start_owner", 32'(bus.owner), 32'(w));
    chk("start_pulse", 32'(bus.req_started), 32'(onehot(w)));
    chk("start_tx_data", 32'(bus.tx_data), 0);
    next_cycle();
    bus.tx_command_started = 1'b0;
  endtask

  // data beats: tx payload follows the owner, strobes go to the owner only
  task automatic xfer(input int w, input int nbeats, input bit rx_every);
    logic [TDW-1:0] tmp;
    logic tdn, rdv;
    for (int k = 0; k < nbeats; k++) begin
      tmp = TDW'($urandom);
      tdn = 1'($urandom);
      rdv = expr[w] ? (rx_every ? 1'b1 : 1'($urandom)) : 1'b0;
      bus.req_tx_data   = tmp;
      bus.tx_data_next  = tdn;
      bus.rx_data_valid = rdv;
      #3;
      chk("xfer_busy", 32'(bus.busy), 1);
      chk("xfer_cmd_valid", 32'(bus.tx_command_valid), 0);
      chk("xfer_tx_data", 32'(bus.tx_data), 32'(tmp[w*IOB +: IOB]));
      chk("xfer_tdn", 32'(bus.req_tx_data_next), tdn ? 32'(onehot(w)) : 0);
      chk("xfer_rdv", 32'(bus.req_rx_data_valid), rdv ? 32'(onehot(w)) : 0);
      chk("xfer_no_done", 32'(bus.req_done), 0);
      if (bus.req_rx_data_valid[0]) rx_seen0++;
      next_cycle();
    end
    bus.tx_data_next  = 1'b0;
    bus.rx_data_valid = 1'b0;
  endtask

  // completion: tx_done, optional RX_WAIT beats, rx_done
  task automatic finish(input int w, input bit same_rx, input int rx_wait);
    logic rdv;
    bus.tx_done = 1'b1;
    bus.rx_done = expr[w] && same_rx;
    #3;
    if (!expr[w] || same_rx) chk("done_at_tx_done", 32'(bus.req_done), 32'(onehot(w)));
    else                     chk("no_done_at_tx_done", 32'(bus.req_done), 0);
    chk("done_perr", 32'(bus.protocol_error), 32'(perr_exp));
    next_cycle();
    bus.tx_done = 1'b0;
    bus.rx_done = 1'b0;
    if (expr[w] && !same_rx) begin
      for (int k = 0; k < rx_wait; k++) begin
        rdv = 1'($urandom);
        bus.rx_data_valid = rdv;
        bus.req_tx_data   = TDW'($urandom);
        #3;
        chk("rxw_busy", 32'(bus.busy), 1);
        chk("rxw_tx_data", 32'(bus.tx_data), 0);
        chk("rxw_rdv", 32'(bus.req_rx_data_valid), rdv ? 32'(onehot(w)) : 0);
        chk("rxw_no_done", 32'(bus.req_done), 0);
        if (bus.req_rx_data_valid[0]) rx_seen0++;
        next_cycle();
      end
      bus.rx_data_valid = 1'b0;
      bus.rx_done       = 1'b1;
      #3;
      chk("rxw_done", 32'(bus.req_done), 32'(onehot(w)));
      next_cycle();
      bus.rx_done = 1'b0;
    end
    bus.req_valid = '0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_cmd_valid", 32'(bus.tx_command_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_perr", 32'(bus.protocol_error), 0);
    chk("rst_cmd", 32'(bus.tx_command), 0);
    bus.req_valid = '0;
    clear_mem_side();
    last_grant = 1;
    perr_exp   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    int w;
    bus.req_valid     = '0;
    bus.req_cmd       = '0;
    bus.req_expect_rx = '0;
    bus.req_tx_data   = '0;
    clear_mem_side();
    last_grant = 1;
    perr_exp   = 1'b0;
    rx_seen0   = 0;

    // reset state
    #12;
    chk("reset_outputs", 32'({bus.tx_command_valid, bus.busy, bus.owner, bus.protocol_error,
                              bus.req_started, bus.req_done, bus.tx_data}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();

    // port 0 read, full 16-bit payload
    start_txn(2'b01, 1'b1, 1'b0, 0, w);
    chk("t1_owner_model", 32'(w), 0);
    xfer(w, PAYLOAD_CYCLES, 1'b1);
    finish(w, 1'b0, 0);
    chk("t1_rx_pulses", 32'(rx_seen0), 32'(PAYLOAD_CYCLES));

    // simultaneous requests after reset: 0,1,0,1
    do_reset();
    for (int k = 0; k < 4; k++) begin
      start_txn(2'b11, 1'($urandom), 1'($urandom), k % 2, w);
      chk("t2_alternate", 32'(w), 32'(k % 2));
      xfer(w, 2, 1'b0);
      finish(w, 1'b0, 1);
    end

    // port 1 write
    start_txn(2'b10, 1'b0, 1'b0, 1, w);
    xfer(w, 4, 1'b0);
    finish(w, 1'b0, 0);
    chk("t3_idle_after_write", 32'(bus.busy), 0);

    // port 0 busy, port 1 joins: port 1 must win the next arbitration
    start_txn(2'b01, 1'b0, 1'b1, 0, w);
    xfer(w, 2, 1'b0);
    finish(w, 1'b0, 0);
    start_txn(2'b11, 1'b0, 1'b1, 0, w);
    chk("t4_port1_next", 32'(w), 1);
    xfer(w, 2, 1'b1);
    finish(w, 1'b1, 0);

    // randomized traffic
    for (int k = 0; k < 12; k++) begin
      start_txn(2'($urandom_range(1, 3)), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)), w);
      xfer(w, int'($urandom_range(1, 4)), 1'b0);
      finish(w, 1'($urandom), int'($urandom_range(0, 3)));
    end

    // asynchronous reset during RX_WAIT with port 1 owning
    start_txn(2'b10, 1'b0, 1'b1, 0, w);
    xfer(w, 2, 1'b1);
    bus.tx_done = 1'b1;
    next_cycle();
    bus.tx_done = 1'b0;
    #2;
    chk("t5_pre_busy", 32'(bus.busy), 1);
    chk("t5_pre_owner", 32'(bus.owner), 1);
    do_reset();
    start_txn(2'b10, 1'b0, 1'b0, 0, w);
    xfer(w, 2, 1'b0);
    finish(w, 1'b0, 0);

    // stray rx_done in IDLE sets a sticky error
    bus.rx_done = 1'b1;
    next_cycle();
    bus.rx_done = 1'b0;
    perr_exp = 1'b1;
    #3;
    chk("t6_perr_set", 32'(bus.protocol_error), 1);
    chk("t6_still_idle", 32'(bus.busy), 0);
    next_cycle();
    start_txn(2'b01, 1'b0, 1'b0, 0, w);
    xfer(w, 1, 1'b0);
    finish(w, 1'b0, 0);
    #3;
    chk("t6_perr_sticky", 32'(bus.protocol_error), 1);
    next_cycle();
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
